// File: rtl/hamster_ramp_pkg.sv
// rtl/hamster_ramp_pkg.sv - shared types for the motor power ramp limiter
//
// Purpose: state encoding of the ramp limiter FSM. The numeric values are
// exported on o_state and read back by the register bank, so they are fixed.
package hamster_ramp_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      RAMP_UP   = 3'd1,
      RAMP_DOWN = 3'd2,
      BRAKE     = 3'd3,
      BYPASS    = 3'd4
   } t_ramp_state;

endpackage

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - prescaler tick generator for the power ramp limiter
//
// Purpose: counts 0..i_prescaler and emits a one-cycle tick on the wrap.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        holds the counter at zero and suppresses the tick
//   i_prescaler    tick period minus one, in clock cycles
//   o_tick         one-cycle tick, combinational from the counter
module ramp_tick_gen
   import hamster_ramp_pkg::*;
#(
   parameter int K_PSC_RES = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   input  logic [K_PSC_RES-1:0] i_prescaler,
   output logic                 o_tick
);

   logic [K_PSC_RES-1:0] cnt_q;
   logic                 wrap;

   // Magnitude compare so a prescaler lowered below the running count
   // still wraps on the next cycle instead of running through the full range.
   assign wrap   = (cnt_q >= i_prescaler);
   assign o_tick = wrap && !i_clear;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         cnt_q <= '0;
      end else if (wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + {{(K_PSC_RES-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/power_ramp_limiter.sv
// rtl/power_ramp_limiter.sv - slew-rate limiter for the motor power command
//
// Purpose: latches each power target and walks o_cmd toward it by
// i_step_up / i_step_down once per prescaler tick. Brake zeroes the output
// immediately; with i_enable low the target is passed straight through.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                1 = ramp limiting, 0 = bypass
//   i_brake                 level-sensitive brake request (highest priority)
//   i_target/_valid         requested power and its one-cycle qualifier
//   i_step_up/i_step_down   step per tick when rising / falling (0 acts as 1)
//   i_prescaler             tick period minus one
//   o_cmd                   limited power command
//   o_cmd_valid             one-cycle pulse after every change of o_cmd
//   o_at_target             o_cmd equals latched target and FSM is in HOLD
//   o_state                 FSM state encoding
module power_ramp_limiter
   import hamster_ramp_pkg::*;
#(
   parameter int K_RES     = 8,
   parameter int K_PSC_RES = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic                 i_brake,
   input  logic [K_RES-1:0]     i_target,
   input  logic                 i_target_valid,
   input  logic [K_RES-1:0]     i_step_up,
   input  logic [K_RES-1:0]     i_step_down,
   input  logic [K_PSC_RES-1:0] i_prescaler,
   output logic [K_RES-1:0]     o_cmd,
   output logic                 o_cmd_valid,
   output logic                 o_at_target,
   output logic [2:0]           o_state
);

   localparam logic [K_RES-1:0] ONE = {{(K_RES-1){1'b0}}, 1'b1};

   t_ramp_state      state_q, state_nxt;
   logic [K_RES-1:0] cmd_q, cmd_nxt;
   logic [K_RES-1:0] target_q;
   logic             cmd_valid_q;

   logic             tick;
   logic             tick_clear;

   logic [K_RES-1:0] step_up_eff, step_down_eff;
   logic [K_RES:0]   diff_up, diff_down;
   logic             target_gt, target_lt;
   logic             up_reach, down_reach;
   logic [K_RES-1:0] up_next, down_next;

   // The prescaler only runs while ramping, so the first step after leaving
   // HOLD lands exactly i_prescaler+1 cycles later. A reversal between the
   // two ramp states keeps the count running.
   assign tick_clear = (state_q != RAMP_UP) && (state_q != RAMP_DOWN);

   ramp_tick_gen #(
      .K_PSC_RES (K_PSC_RES)
   ) u_tick_gen (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (tick_clear),
      .i_prescaler (i_prescaler),
      .o_tick      (tick)
   );

   // Zero step would stall the ramp forever; treat it as the smallest step.
   assign step_up_eff   = (i_step_up   == '0) ? ONE : i_step_up;
   assign step_down_eff = (i_step_down == '0) ? ONE : i_step_down;

   assign target_gt = (target_q > cmd_q);
   assign target_lt = (target_q < cmd_q);

   // One extra bit so the distance never wraps; each difference is only
   // used in the direction where it is non-negative.
   assign diff_up   = {1'b0, target_q} - {1'b0, cmd_q};
   assign diff_down = {1'b0, cmd_q} - {1'b0, target_q};

   // Clamp to the target when the remaining distance fits in one step;
   // otherwise the step cannot overflow since cmd + step < target.
   assign up_reach   = (diff_up   <= {1'b0, step_up_eff});
   assign down_reach = (diff_down <= {1'b0, step_down_eff});
   assign up_next    = up_reach   ? target_q : (cmd_q + step_up_eff);
   assign down_next  = down_reach ? target_q : (cmd_q - step_down_eff);

   always_comb begin
      state_nxt = state_q;
      cmd_nxt   = cmd_q;

      if (i_brake) begin
         state_nxt = BRAKE;
         cmd_nxt   = '0;
      end else if (!i_enable) begin
         state_nxt = BYPASS;
         cmd_nxt   = target_q;
      end else begin
         case (state_q)
            BRAKE: begin
               state_nxt = HOLD;
               cmd_nxt   = '0;
            end
            BYPASS: begin
               // Keep the passed-through value; ramping resumes from here.
               state_nxt = HOLD;
            end
            default: begin
               // HOLD and both ramp states: direction follows the latched
               // target every cycle, stepping only on a tick.
               if (target_gt) begin
                  state_nxt = RAMP_UP;
                  if (tick) begin
                     cmd_nxt = up_next;
                     if (up_reach) begin
                        state_nxt = HOLD;
                     end
                  end
               end else if (target_lt) begin
                  state_nxt = RAMP_DOWN;
                  if (tick) begin
                     cmd_nxt = down_next;
                     if (down_reach) begin
                        state_nxt = HOLD;
                     end
                  end
               end else begin
                  state_nxt = HOLD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= HOLD;
         cmd_q       <= '0;
         target_q    <= '0;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cmd_q       <= cmd_nxt;
         cmd_valid_q <= (cmd_nxt != cmd_q);
         // Targets are latched in every state, including BRAKE. The FSM sees
         // the new value one cycle later, so a coinciding tick uses the old one.
         if (i_target_valid) begin
            target_q <= i_target;
         end
      end
   end

   assign o_cmd       = cmd_q;
   assign o_cmd_valid = cmd_valid_q;
   assign o_at_target = (state_q == HOLD) && (cmd_q == target_q);
   assign o_state     = state_q;

endmodule

// File: tb/tb_power_ramp_limiter.sv
// tb/tb_power_ramp_limiter.sv - directed self-checking bench for power_ramp_limiter
module tb_power_ramp_limiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        brake = 1'b0;
   logic [7:0]  target = 8'd0;
   logic        target_valid = 1'b0;
   logic [7:0]  step_up = 8'd1;
   logic [7:0]  step_down = 8'd1;
   logic [15:0] prescaler = 16'd0;
   logic [7:0]  cmd;
   logic        cmd_valid;
   logic        at_target;
   logic [2:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   power_ramp_limiter #(
      .K_RES     (8),
      .K_PSC_RES (16)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (enable),
      .i_brake        (brake),
      .i_target       (target),
      .i_target_valid (target_valid),
      .i_step_up      (step_up),
      .i_step_down    (step_down),
      .i_prescaler    (prescaler),
      .o_cmd          (cmd),
      .o_cmd_valid    (cmd_valid),
      .o_at_target    (at_target),
      .o_state        (state)
   );

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_target(input logic [7:0] t);
      target = t;
      target_valid = 1'b1;
      cyc();
      target_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (cmd !== 8'd0) begin n_fail++; $display("FAIL reset_cmd got %0d want 0", cmd); end
      n_tests++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
      n_tests++;
      if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
      n_tests++;
      if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target got %b want 1", at_target); end
      rst = 1'b0;
   endtask

   task automatic test_ramp_up();
      int exp_seq [5] = '{10, 20, 30, 40, 45};
      int k = 0;
      int last_i = 0;
      int pulses = 0;
      logic [7:0] prev;
      enable = 1'b1;
      prescaler = 16'd3;
      step_up = 8'd10;
      load_target(8'd45);
      prev = cmd;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (cmd_valid === 1'b1) pulses++;
         n_tests++;
         if (cmd_valid !== (cmd !== prev)) begin
            n_fail++;
            $display("FAIL up_valid_pulse cycle %0d got %b want %b", i, cmd_valid, (cmd !== prev));
         end
         if (cmd !== prev) begin
            n_tests++;
            if (k >= 5 || cmd !== exp_seq[k[2:0]]) begin
               n_fail++;
               $display("FAIL up_value step %0d got %0d want %0d", k, cmd, (k < 5) ? exp_seq[k[2:0]] : -1);
            end
            n_tests++;
            if ((k == 0 && i != 5) || (k > 0 && i - last_i != 4)) begin
               n_fail++;
               $display("FAIL up_spacing step %0d got cycle %0d want %0d", k, i, (k == 0) ? 5 : last_i + 4);
            end
            last_i = i;
            k++;
         end
         prev = cmd;
      end
      n_tests++;
      if (pulses != 5) begin n_fail++; $display("FAIL up_pulse_count got %0d want 5", pulses); end
      n_tests++;
      if (cmd !== 8'd45 || state !== 3'd0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL up_final got cmd=%0d state=%0d at=%b want 45/0/1", cmd, state, at_target);
      end
   endtask

   task automatic test_ramp_down();
      int exp_seq [6] = '{200, 140, 80, 50, 50, 50};
      prescaler = 16'd0;
      step_up = 8'd200;
      load_target(8'd200);
      cyc();
      cyc();
      n_tests++;
      if (cmd !== 8'd200) begin n_fail++; $display("FAIL down_setup got %0d want 200", cmd); end
      step_down = 8'd60;
      load_target(8'd50);
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_tests++;
         if (cmd !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL down_value cycle %0d got %0d want %0d", i, cmd, exp_seq[i]);
         end
         if (i == 0) begin
            n_tests++;
            if (state !== 3'd2) begin n_fail++; $display("FAIL down_state got %0d want 2", state); end
         end
         if (i == 3) begin
            n_tests++;
            if (state !== 3'd0 || at_target !== 1'b1) begin
               n_fail++;
               $display("FAIL down_hold got state=%0d at=%b want 0/1", state, at_target);
            end
         end
      end
   endtask

   task automatic test_brake();
      prescaler = 16'd0;
      step_up = 8'd10;
      load_target(8'd200);
      repeat (8) cyc();
      n_tests++;
      if (cmd !== 8'd120 || state !== 3'd1) begin
         n_fail++;
         $display("FAIL brake_setup got cmd=%0d state=%0d want 120/1", cmd, state);
      end
      brake = 1'b1;
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd3 || cmd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL brake_entry got cmd=%0d state=%0d valid=%b want 0/3/1", cmd, state, cmd_valid);
      end
      load_target(8'd120);
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd3) begin
         n_fail++;
         $display("FAIL brake_hold got cmd=%0d state=%0d want 0/3", cmd, state);
      end
      brake = 1'b0;
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL brake_release got cmd=%0d state=%0d want 0/0", cmd, state);
      end
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd1) begin
         n_fail++;
         $display("FAIL brake_restart got cmd=%0d state=%0d want 0/1", cmd, state);
      end
      cyc();
      n_tests++;
      if (cmd !== 8'd10) begin n_fail++; $display("FAIL brake_first_step got %0d want 10", cmd); end
   endtask

   task automatic test_bypass();
      enable = 1'b0;
      load_target(8'd255);
      n_tests++;
      if (state !== 3'd4 || cmd !== 8'd120) begin
         n_fail++;
         $display("FAIL bypass_entry got state=%0d cmd=%0d want 4/120", state, cmd);
      end
      cyc();
      n_tests++;
      if (cmd !== 8'd255) begin n_fail++; $display("FAIL bypass_follow got %0d want 255", cmd); end
      enable = 1'b1;
      step_down = 8'd100;
      prescaler = 16'd0;
      cyc();
      n_tests++;
      if (state !== 3'd0 || cmd !== 8'd255) begin
         n_fail++;
         $display("FAIL bypass_exit got state=%0d cmd=%0d want 0/255", state, cmd);
      end
      load_target(8'd0);
      cyc();
      n_tests++;
      if (state !== 3'd2 || cmd !== 8'd255) begin
         n_fail++;
         $display("FAIL bypass_down_start got state=%0d cmd=%0d want 2/255", state, cmd);
      end
      cyc();
      n_tests++;
      if (cmd !== 8'd155) begin n_fail++; $display("FAIL bypass_down1 got %0d want 155", cmd); end
      cyc();
      n_tests++;
      if (cmd !== 8'd55) begin n_fail++; $display("FAIL bypass_down2 got %0d want 55", cmd); end
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass_down3 got cmd=%0d state=%0d at=%b want 0/0/1", cmd, state, at_target);
      end
   endtask

   task automatic test_edge_cases();
      logic reached = 1'b0;
      prescaler = 16'd0;
      step_up = 8'd10;
      step_down = 8'd40;
      load_target(8'd200);
      repeat (9) cyc();
      n_tests++;
      if (cmd !== 8'd80 || state !== 3'd1) begin
         n_fail++;
         $display("FAIL rev_setup got cmd=%0d state=%0d want 80/1", cmd, state);
      end
      // Coincides with a tick: this step still heads for the old target.
      load_target(8'd30);
      n_tests++;
      if (cmd !== 8'd90) begin n_fail++; $display("FAIL rev_old_target got %0d want 90", cmd); end
      cyc();
      n_tests++;
      if (state !== 3'd2) begin n_fail++; $display("FAIL rev_direction got %0d want 2", state); end
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if (cmd < 8'd30 || cmd > 8'd90) begin
            n_fail++;
            $display("FAIL rev_bound cycle %0d got %0d want 30..90", i, cmd);
         end
         if (cmd == 8'd30 && state == 3'd0) reached = 1'b1;
         cyc();
      end
      n_tests++;
      if (!reached || cmd !== 8'd30) begin
         n_fail++;
         $display("FAIL rev_settle got cmd=%0d reached=%b want 30/1", cmd, reached);
      end

      step_up = 8'd0;
      load_target(8'd33);
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_tests++;
         if (cmd !== 8'(30 + i)) begin
            n_fail++;
            $display("FAIL zero_step cycle %0d got %0d want %0d", i, cmd, 30 + i);
         end
      end
      n_tests++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL zero_step_hold got %0d want 0", state); end

      step_up = 8'd200;
      load_target(8'd100);
      cyc();
      cyc();
      n_tests++;
      if (cmd !== 8'd100) begin n_fail++; $display("FAIL wrap_setup got %0d want 100", cmd); end
      load_target(8'd255);
      cyc();
      cyc();
      n_tests++;
      if (cmd !== 8'd255 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL no_wrap got cmd=%0d state=%0d want 255/0", cmd, state);
      end
   endtask

   task automatic test_reset_mid_ramp();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      prescaler = 16'd0;
      step_up = 8'd10;
      load_target(8'd200);
      repeat (8) cyc();
      n_tests++;
      if (cmd !== 8'd70 || state !== 3'd1) begin
         n_fail++;
         $display("FAIL rst_setup got cmd=%0d state=%0d want 70/1", cmd, state);
      end
      rst = 1'b1;
      brake = 1'b1;
      enable = 1'b0;
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd0 || cmd_valid !== 1'b0 || at_target !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid got cmd=%0d state=%0d valid=%b at=%b want 0/0/0/1", cmd, state, cmd_valid, at_target);
      end
      rst = 1'b0;
      brake = 1'b0;
      enable = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (cmd !== 8'd0 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_target_cleared got cmd=%0d state=%0d want 0/0", cmd, state);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_brake();
      test_bypass();
      test_edge_cases();
      test_reset_mid_ramp();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
